// File: rtl/sysbus_uart_pkg.sv
// sysbus_uart_pkg
// Shared constants and types for the sysbus UART transmitter: register
// offsets inside the four-word window, STATUS bit positions and the
// transmit FSM state type.

package sysbus_uart_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_BAUD   = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Small synchronous FIFO that queues bytes between the CPU write port and
// the serialiser. Pointers carry one extra wrap bit so full and empty can be
// told apart without a separate counter. A push into a full FIFO or a pop
// from an empty one is ignored here as a safety net; the parent already
// gates both.

module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             n_reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wrPtr_q;
   logic [PTR_W:0]   rdPtr_q;
   logic             doPush;
   logic             doPop;

   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                    (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
   assign dout_o  = mem_q[rdPtr_q[PTR_W-1:0]];

   // Storage array; contents need no reset because empty pointers hide them
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem_q[wrPtr_q[PTR_W-1:0]] <= din_i;
      end
   end

   // Read and write pointers; simultaneous push and pop leaves occupancy unchanged
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/sysbus_uart_tx.sv
// sysbus_uart_tx
// Memory-mapped UART transmitter sitting as a target on the CPU sysbus.
// Bytes written to TXDATA are queued in uart_tx_fifo and sent on txd as
// start / 8 data bits LSB first / stop frames, each bit lasting BAUDDIV+1
// clocks. STATUS exposes {ovf, empty, full, busy} for polling firmware.
// Build option: define UART_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit (11-bit frames instead of 10).

module sysbus_uart_tx
   import sysbus_uart_pkg::*;
#(
   parameter int                     WORD_W     = 8,
   parameter int                     OP_W       = 3,
   parameter logic [WORD_W-OP_W-1:0] BASE_ADDR  = 5'h1C,
   parameter int                     FIFO_DEPTH = 4,
   parameter logic [WORD_W-1:0]      BAUD_RST   = 8'd3
) (
   input  logic                     clock,
   input  logic                     n_reset,
   input  logic [WORD_W-OP_W-1:0]   addr,
   input  logic                     CS,
   input  logic                     R_NW,
   inout  wire  [WORD_W-1:0]        sysbus,
   output logic                     txd,
   output logic                     tx_irq
);

   localparam int ADDR_W = WORD_W - OP_W;
   localparam int CNT_W  = $clog2(WORD_W);

   logic              hit;
   logic [1:0]        off;
   logic              rdEn;
   logic              wrEn;
   logic              wrTxData;
   logic              push;
   logic              pop;
   logic              ovfSet;
   logic              statusRd;
   logic              wrBaud;
   logic [WORD_W-1:0] rdata;

   logic              fifoFull;
   logic              fifoEmpty;
   logic [WORD_W-1:0] fifoDout;

   logic [WORD_W-1:0] baudDiv_q;
   logic [WORD_W-1:0] baudDiv_d;
   logic              ovf_q;
   logic              ovf_d;

   tx_state_t         state_q;
   logic              txd_q;
   logic              irq_q;
   logic [WORD_W-1:0] shift_q;
   logic [CNT_W-1:0]  bitCnt_q;
   logic [WORD_W-1:0] baudCnt_q;
`ifdef UART_PARITY_EN
   logic              parity_q;
`endif

   logic              bitDone;
   logic              lastBit;

   assign hit      = CS && (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
   assign off      = addr[1:0];
   assign rdEn     = hit && R_NW;
   assign wrEn     = hit && !R_NW;
   assign wrTxData = wrEn && (off == OFF_TXDATA);
   assign push     = wrTxData && !fifoFull;
   assign ovfSet   = wrTxData && fifoFull;
   assign statusRd = rdEn && (off == OFF_STATUS);
   assign wrBaud   = wrEn && (off == OFF_BAUD);
   assign pop      = (state_q == TX_IDLE) && !fifoEmpty;

   assign bitDone  = (baudCnt_q == '0);
   assign lastBit  = (bitCnt_q == CNT_W'(WORD_W-1));

   assign sysbus   = rdEn ? rdata : 'z;
   assign txd      = txd_q;
   assign tx_irq   = irq_q;

   uart_tx_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clock   (clock),
      .n_reset (n_reset),
      .push_i  (push),
      .din_i   (sysbus),
      .pop_i   (pop),
      .dout_o  (fifoDout),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   // Read data mux for the register window; TXDATA and the reserved slot read as zero
   always_comb begin
      rdata = '0;
      unique case (off)
         OFF_STATUS: begin
            rdata[STAT_BUSY]  = (state_q != TX_IDLE);
            rdata[STAT_FULL]  = fifoFull;
            rdata[STAT_EMPTY] = fifoEmpty;
            rdata[STAT_OVF]   = ovf_q;
         end
         OFF_BAUD:   rdata = baudDiv_q;
         OFF_TXDATA: rdata = '0;
         OFF_RSVD:   rdata = '0;
         default:    rdata = '0;
      endcase
   end

   // Next-state for the writable divider and the sticky overflow flag (a new overflow beats a clearing STATUS read)
   always_comb begin
      baudDiv_d = baudDiv_q;
      ovf_d     = ovf_q;
      if (wrBaud) begin
         baudDiv_d = sysbus;
      end
      if (ovfSet) begin
         ovf_d = 1'b1;
      end else if (statusRd) begin
         ovf_d = 1'b0;
      end
   end

   // Control register storage
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         baudDiv_q <= BAUD_RST;
         ovf_q     <= 1'b0;
      end else begin
         baudDiv_q <= baudDiv_d;
         ovf_q     <= ovf_d;
      end
   end

   // Transmit FSM: every bit lasts until the baud counter hits zero, then it reloads from the live divider
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= TX_IDLE;
         txd_q     <= 1'b1;
         irq_q     <= 1'b1;
         shift_q   <= '0;
         bitCnt_q  <= '0;
         baudCnt_q <= '0;
`ifdef UART_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         irq_q <= fifoEmpty && (state_q == TX_IDLE);
         unique case (state_q)
            TX_IDLE: begin
               if (!fifoEmpty) begin
                  shift_q   <= fifoDout;
                  baudCnt_q <= baudDiv_q;
                  txd_q     <= 1'b0;
                  state_q   <= TX_START;
`ifdef UART_PARITY_EN
                  parity_q  <= ^fifoDout;
`endif
               end
            end
            TX_START: begin
               if (bitDone) begin
                  txd_q     <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bitCnt_q  <= '0;
                  baudCnt_q <= baudDiv_q;
                  state_q   <= TX_DATA;
               end else begin
                  baudCnt_q <= baudCnt_q - 1'b1;
               end
            end
            TX_DATA: begin
               if (bitDone) begin
                  baudCnt_q <= baudDiv_q;
                  if (lastBit) begin
`ifdef UART_PARITY_EN
                     txd_q   <= parity_q;
                     state_q <= TX_PARITY;
`else
                     txd_q   <= 1'b1;
                     state_q <= TX_STOP;
`endif
                  end else begin
                     txd_q    <= shift_q[0];
                     shift_q  <= shift_q >> 1;
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end else begin
                  baudCnt_q <= baudCnt_q - 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
               if (bitDone) begin
                  txd_q     <= 1'b1;
                  baudCnt_q <= baudDiv_q;
                  state_q   <= TX_STOP;
               end else begin
                  baudCnt_q <= baudCnt_q - 1'b1;
               end
            end
`endif
            TX_STOP: begin
               if (bitDone) begin
                  txd_q   <= 1'b1;
                  state_q <= TX_IDLE;
               end else begin
                  baudCnt_q <= baudCnt_q - 1'b1;
               end
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysbus_uart_tx.sv
// tb_sysbus_uart_tx
// Directed bench for sysbus_uart_tx: a table of register accesses followed by
// hand-written serial-frame sequences. Build with UART_PARITY_EN defined to
// exercise the parity frame as well.

module tb_sysbus_uart_tx;

   localparam int CPB = 4;

   typedef struct {
      logic       cs;
      logic       rnw;
      logic [4:0] a;
      logic [7:0] wd;
      logic [7:0] exp;
      string      name;
   } vec_t;

   logic       clock = 1'b0;
   logic       n_reset;
   logic [4:0] addr;
   logic       CS;
   logic       R_NW;
   wire  [7:0] sysbus;
   logic [7:0] drvData;
   logic       drvEn;
   logic       txd;
   logic       tx_irq;

   int checks = 0;
   int fails  = 0;

   vec_t vecs[19];

   assign sysbus = drvEn ? drvData : 8'bz;

   for (genvar i = 0; i < 8; i++) begin : gPull
      pullup (sysbus[i]);
   end

   always #5 clock = ~clock;

   sysbus_uart_tx dut (
      .clock   (clock),
      .n_reset (n_reset),
      .addr    (addr),
      .CS      (CS),
      .R_NW    (R_NW),
      .sysbus  (sysbus),
      .txd     (txd),
      .tx_irq  (tx_irq)
   );

   // Compare one value and log a failure line when it differs
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One bus access starting at a falling edge, spanning exactly one rising edge
   task automatic applyStimulus(input logic cs, input logic rnw, input logic [4:0] a,
                                input logic [7:0] wd, output logic [7:0] rd);
      CS      = cs;
      R_NW    = rnw;
      addr    = a;
      drvData = wd;
      drvEn   = cs && !rnw;
      #2;
      rd = sysbus;
      @(negedge clock);
      CS    = 1'b0;
      R_NW  = 1'b1;
      drvEn = 1'b0;
   endtask

   task automatic busWrite(input logic [4:0] a, input logic [7:0] d);
      logic [7:0] dummy;
      applyStimulus(1'b1, 1'b0, a, d, dummy);
   endtask

   task automatic busReadCheck(input logic [4:0] a, input logic [7:0] exp, input string name);
      logic [7:0] rd;
      applyStimulus(1'b1, 1'b1, a, 8'h00, rd);
      checkOutput(name, rd, exp);
   endtask

   // Expected txd sample per clock for a frame; bits below nFirst last cpbFirst clocks, the rest cpbRest
   task automatic buildFrame(input logic [7:0] data, input int cpbFirst, input int nFirst,
                             input int cpbRest, output logic [63:0] pat, output int n);
      logic [10:0] seq;
      int nb;
      int reps;
      seq = '0;
      seq[0] = 1'b0;
      for (int i = 0; i < 8; i++) seq[i+1] = data[i];
      nb = 9;
`ifdef UART_PARITY_EN
      seq[nb] = ^data;
      nb++;
`endif
      seq[nb] = 1'b1;
      nb++;
      pat = '0;
      n = 0;
      for (int b = 0; b < nb; b++) begin
         reps = (b < nFirst) ? cpbFirst : cpbRest;
         for (int c = 0; c < reps; c++) begin
            pat[n] = seq[b];
            n++;
         end
      end
   endtask

   // Check txd against samples [from, to) of a pattern, one per falling edge
   task automatic checkSamples(input logic [63:0] pat, input int from, input int to, input string name);
      for (int i = from; i < to; i++) begin
         checks++;
         if (txd !== pat[i]) begin
            fails++;
            $display("[TB] FAIL %s sample %0d: got %b, expected %b", name, i, txd, pat[i]);
         end
         @(negedge clock);
      end
   endtask

   // Wait (bounded) for the start bit; returns the number of falling edges waited
   task automatic waitFall(input string name, output int cnt);
      cnt = 0;
      while (txd !== 1'b0 && cnt < 200) begin
         @(negedge clock);
         cnt++;
      end
      checks++;
      if (txd !== 1'b0) begin
         fails++;
         $display("[TB] FAIL %s start bit: got txd %b, expected 0 within 200 clocks", name, txd);
      end
   endtask

   task automatic expectFrame(input logic [7:0] data, input int cpb, input int expWait, input string name);
      int cnt;
      int n;
      logic [63:0] pat;
      waitFall(name, cnt);
      if (expWait >= 0) checkOutput({name, " latency"}, 8'(cnt), 8'(expWait));
      buildFrame(data, cpb, 99, cpb, pat, n);
      checkSamples(pat, 0, n, name);
   endtask

   task automatic expectQuiet(input int cycles, input string name);
      logic sawLow;
      sawLow = 1'b0;
      repeat (cycles) begin
         if (txd !== 1'b1) sawLow = 1'b1;
         @(negedge clock);
      end
      checkOutput(name, 8'(sawLow), 8'h00);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt;
      int n;
      logic [63:0] pat;
      logic [7:0] rd;

      vecs[0]  = '{1'b1, 1'b1, 5'h1D, 8'h00, 8'h04, "status reset"};
      vecs[1]  = '{1'b1, 1'b1, 5'h1E, 8'h00, 8'h03, "baud reset"};
      vecs[2]  = '{1'b1, 1'b1, 5'h1C, 8'h00, 8'h00, "txdata read zero"};
      vecs[3]  = '{1'b1, 1'b1, 5'h1F, 8'h00, 8'h00, "reserved read zero"};
      vecs[4]  = '{1'b1, 1'b0, 5'h1E, 8'h5A, 8'h00, "baud write"};
      vecs[5]  = '{1'b1, 1'b1, 5'h1E, 8'h00, 8'h5A, "baud readback"};
      vecs[6]  = '{1'b1, 1'b0, 5'h1F, 8'h77, 8'h00, "reserved write"};
      vecs[7]  = '{1'b1, 1'b1, 5'h1F, 8'h00, 8'h00, "reserved write ignored"};
      vecs[8]  = '{1'b1, 1'b0, 5'h1D, 8'hFF, 8'h00, "status write"};
      vecs[9]  = '{1'b1, 1'b1, 5'h1D, 8'h00, 8'h04, "status write ignored"};
      vecs[10] = '{1'b0, 1'b1, 5'h1D, 8'h00, 8'hFF, "bus released cs low"};
      vecs[11] = '{1'b1, 1'b1, 5'h19, 8'h00, 8'hFF, "bus released miss"};
      vecs[12] = '{1'b1, 1'b0, 5'h1A, 8'h00, 8'h00, "miss baud write"};
      vecs[13] = '{1'b1, 1'b1, 5'h1E, 8'h00, 8'h5A, "miss write ignored"};
      vecs[14] = '{1'b1, 1'b0, 5'h18, 8'h33, 8'h00, "miss txdata write"};
      vecs[15] = '{1'b0, 1'b0, 5'h1C, 8'h44, 8'h00, "cs low txdata write"};
      vecs[16] = '{1'b1, 1'b1, 5'h1D, 8'h00, 8'h04, "no push on miss"};
      vecs[17] = '{1'b1, 1'b0, 5'h1E, 8'h03, 8'h00, "baud restore"};
      vecs[18] = '{1'b1, 1'b1, 5'h1E, 8'h00, 8'h03, "baud restored"};

      n_reset = 1'b0;
      CS      = 1'b0;
      R_NW    = 1'b1;
      addr    = '0;
      drvData = '0;
      drvEn   = 1'b0;

      #12;
      checkOutput("reset txd", 8'(txd), 8'h01);
      checkOutput("reset tx_irq", 8'(tx_irq), 8'h01);
      @(negedge clock);
      n_reset = 1'b1;
      @(negedge clock);
      checkOutput("post reset txd", 8'(txd), 8'h01);

      $display("[TB] register access table");
      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].cs, vecs[i].rnw, vecs[i].a, vecs[i].wd, rd);
         if (vecs[i].rnw) checkOutput(vecs[i].name, rd, vecs[i].exp);
      end
      checkOutput("table txd idle", 8'(txd), 8'h01);

      $display("[TB] single byte A5 at BAUDDIV=3");
      busWrite(5'h1C, 8'hA5);
      expectFrame(8'hA5, CPB, 1, "frame A5");
      busReadCheck(5'h1D, 8'h04, "status after A5");
      checkOutput("tx_irq after A5", 8'(tx_irq), 8'h01);

      $display("[TB] single byte 3C at BAUDDIV=0");
      busWrite(5'h1E, 8'h00);
      busWrite(5'h1C, 8'h3C);
      expectFrame(8'h3C, 1, 1, "frame 3C div0");
      busWrite(5'h1E, 8'h03);

      $display("[TB] FIFO fill and overflow");
      busWrite(5'h1C, 8'h11);
      busWrite(5'h1C, 8'h22);
      busWrite(5'h1C, 8'h33);
      busWrite(5'h1C, 8'h44);
      busWrite(5'h1C, 8'h55);
      busWrite(5'h1C, 8'h66);
      busReadCheck(5'h1D, 8'h0B, "status overflow set");
      busReadCheck(5'h1D, 8'h03, "status overflow cleared");
      buildFrame(8'h11, CPB, 99, CPB, pat, n);
      checkSamples(pat, 6, n, "frame 11");
      expectFrame(8'h22, CPB, 1, "frame 22");
      expectFrame(8'h33, CPB, 1, "frame 33");
      expectFrame(8'h44, CPB, 1, "frame 44");
      expectFrame(8'h55, CPB, 1, "frame 55");
      expectQuiet(60, "dropped byte not sent");
      busReadCheck(5'h1D, 8'h04, "status after burst");

      $display("[TB] BAUDDIV change mid-frame");
      busWrite(5'h1C, 8'h0F);
      waitFall("frame 0F", cnt);
      checkOutput("frame 0F latency", 8'(cnt), 8'h01);
      buildFrame(8'h0F, CPB, 3, 1, pat, n);
      checkSamples(pat, 0, 10, "frame 0F");
      busWrite(5'h1E, 8'h00);
      checkSamples(pat, 11, n, "frame 0F");
      busWrite(5'h1E, 8'h03);
      busReadCheck(5'h1D, 8'h04, "status after 0F");

      $display("[TB] reset mid-frame");
      busWrite(5'h1E, 8'h05);
      busWrite(5'h1C, 8'h00);
      busWrite(5'h1C, 8'h00);
      waitFall("frame 00", cnt);
      busReadCheck(5'h1D, 8'h01, "status mid-frame busy");
      checkOutput("tx_irq mid-frame", 8'(tx_irq), 8'h00);
      repeat (10) @(negedge clock);
      checkOutput("txd low in data", 8'(txd), 8'h00);
      #2;
      n_reset = 1'b0;
      #1;
      checkOutput("txd on async reset", 8'(txd), 8'h01);
      checkOutput("tx_irq on async reset", 8'(tx_irq), 8'h01);
      @(negedge clock);
      n_reset = 1'b1;
      @(negedge clock);
      busReadCheck(5'h1D, 8'h04, "status after reset");
      busReadCheck(5'h1E, 8'h03, "baud after reset");
      expectQuiet(60, "no residual frame");

`ifdef UART_PARITY_EN
      $display("[TB] parity frame 07");
      busWrite(5'h1C, 8'h07);
      expectFrame(8'h07, CPB, 1, "parity frame 07");
      busReadCheck(5'h1D, 8'h04, "status after parity frame");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
